// File: rtl/csm_pkg.sv
// Shared types and default parameters for the CSM port sequencer.
package csm_pkg;

  typedef enum logic [1:0] {
    NO_ERROR   = 2'd0,
    IN_USE     = 2'd1,
    DUAL_WRITE = 2'd2,
    DUAL_HOLD  = 2'd3
  } csm_err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ADDR,
    S_DATA,
    S_RELEASE,
    S_BACKOFF,
    S_RESP
  } port_state_t;

  localparam int unsigned CSM_DATABITS       = 8;
  localparam int unsigned CSM_MEMSIZE        = 8;
  localparam int unsigned CSM_MAX_RETRY      = 3;
  localparam int unsigned CSM_BACKOFF_CYCLES = 2;

endpackage

// File: rtl/csm_backoff_timer.sv
// Loadable down-counter; expire flags the last backoff cycle (count == 1).
module csm_backoff_timer #(
  parameter int unsigned LOAD_VAL = csm_pkg::CSM_BACKOFF_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic dec,
  output logic expire
);

  localparam int unsigned W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD_VAL);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/csm_port_master.sv
// Processor-side request sequencer for one CSM port: hold, enable+address, data,
// optional release, with retry/backoff on CSM errors and one response per request.
//   state   | meaning
//   IDLE    | ready for a request
//   HOLD    | requesting the hold (lock)
//   ADDR    | enable asserted, address on mem_ad
//   DATA    | write data on mem_ad / read data captured
//   RELEASE | dropping the hold
//   BACKOFF | waiting before repeating the failed step
//   RESP    | one-cycle response strobe
module csm_port_master
  import csm_pkg::*;
#(
  parameter int unsigned DATABITS       = CSM_DATABITS,
  parameter int unsigned MEMSIZE        = CSM_MEMSIZE,
  parameter int unsigned MAX_RETRY      = CSM_MAX_RETRY,
  parameter int unsigned BACKOFF_CYCLES = CSM_BACKOFF_CYCLES,
  localparam int unsigned ADDRBITS      = $clog2(MEMSIZE)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_lock,
  input  logic                req_unlock,
  input  logic [ADDRBITS-1:0] req_addr,
  input  logic [DATABITS-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [DATABITS-1:0] rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                locked,
  output logic [DATABITS-1:0] mem_ad,
  output logic                mem_rw,
  output logic                mem_enable,
  output logic                mem_hold,
  output logic                mem_release,
  input  logic [DATABITS-1:0] mem_rdata,
  input  logic                mem_ack,
  input  logic [1:0]          mem_err
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  port_state_t         state;
  logic [RW-1:0]       retry_cnt;
  logic                cap_write, cap_lock, cap_unlock;
  logic [ADDRBITS-1:0] cap_addr;
  logic [DATABITS-1:0] cap_wdata;
  logic [DATABITS-1:0] rdata_q;
  csm_err_t            last_err;
  csm_err_t            err_in;
  logic                fail_now, retry_left, bo_expire;

  assign err_in     = csm_err_t'(mem_err);
  assign fail_now   = ((state == S_HOLD) && !(mem_ack && (err_in == NO_ERROR))) ||
                      ((state == S_ADDR) && (err_in != NO_ERROR));
  assign retry_left = (retry_cnt != RW'(MAX_RETRY));

  csm_backoff_timer #(.LOAD_VAL(BACKOFF_CYCLES)) u_backoff (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (fail_now && retry_left),
    .dec     (state == S_BACKOFF),
    .expire  (bo_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      locked     <= 1'b0;
      retry_cnt  <= '0;
      cap_write  <= 1'b0;
      cap_lock   <= 1'b0;
      cap_unlock <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rdata_q    <= '0;
      last_err   <= NO_ERROR;
    end else if (fail_now) begin
      last_err <= err_in;
      if (retry_left) begin
        retry_cnt <= retry_cnt + RW'(1);
        state     <= S_BACKOFF;
      end else begin
        state <= S_RESP;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cap_write  <= req_write;
            cap_lock   <= req_lock;
            cap_unlock <= req_unlock;
            cap_addr   <= req_addr;
            cap_wdata  <= req_wdata;
            retry_cnt  <= '0;
            rdata_q    <= '0;
            last_err   <= NO_ERROR;
            state      <= (req_lock && !locked) ? S_HOLD : S_ADDR;
          end
        end
        S_HOLD: begin
          locked <= 1'b1;
          state  <= S_ADDR;
        end
        S_ADDR: state <= S_DATA;
        S_DATA: begin
          if (!cap_write) rdata_q <= mem_rdata;
          // a retried access that finally succeeds reports success
          last_err <= NO_ERROR;
          state    <= (cap_unlock && locked) ? S_RELEASE : S_RESP;
        end
        S_RELEASE: begin
          locked <= 1'b0;
          state  <= S_RESP;
        end
        S_BACKOFF: begin
          if (bo_expire) state <= (cap_lock && !locked) ? S_HOLD : S_ADDR;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign rsp_valid   = (state == S_RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid ? last_err : NO_ERROR;
  assign mem_hold    = (state == S_HOLD);
  assign mem_enable  = (state == S_ADDR);
  assign mem_rw      = (state == S_ADDR) && cap_write;
  assign mem_release = (state == S_RELEASE);
  assign mem_ad      = (state == S_ADDR)              ? DATABITS'(cap_addr) :
                       ((state == S_DATA) && cap_write) ? cap_wdata : '0;

endmodule

// File: tb/tb_csm_port_master.sv
// Directed bench for csm_port_master; responses checked through a scoreboard queue.
module tb_csm_port_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready, req_write, req_lock, req_unlock;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       locked;
  logic [7:0] mem_ad;
  logic       mem_rw, mem_enable, mem_hold, mem_release;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic [1:0] mem_err;

  csm_port_master dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_lock(req_lock), .req_unlock(req_unlock), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .locked(locked), .mem_ad(mem_ad), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_hold(mem_hold), .mem_release(mem_release),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] rd;
    logic [1:0] err;
    int         at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every response must match the oldest expectation, at its cycle
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rd));
        chk("rsp_err",   int'(rsp_err),   int'(e.err));
        chk("rsp_cycle", cyc,             e.at);
      end
    end
  end

  // called at the negedge of cycle 0; returns at the negedge of cycle 1
  task automatic start_req(input logic wr, input logic lk, input logic ul,
                           input logic [2:0] a, input logic [7:0] wd,
                           input bit expect_rsp, input logic [7:0] rd,
                           input logic [1:0] err, input int lat);
    exp_t e;
    chk("req_ready_idle", int'(req_ready), 1);
    req_valid = 1'b1; req_write = wr; req_lock = lk; req_unlock = ul;
    req_addr = a; req_wdata = wd;
    if (expect_rsp) begin
      e.rd = rd; e.err = err; e.at = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("req_ready_busy", int'(req_ready), 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = 0; req_write = 0; req_lock = 0; req_unlock = 0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 0; mem_err = 2'd0;
    step(); step();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_rdata", int'(rsp_rdata), 0);
    chk("rst_rsp_err",   int'(rsp_err),   0);
    chk("rst_locked",    int'(locked),    0);
    chk("rst_mem_ctl",   int'({mem_rw, mem_enable, mem_hold, mem_release}), 0);
    chk("rst_mem_ad",    int'(mem_ad),    0);
    reset_n = 1'b1;
    step();

    // plain write addr 5 data 0xA5
    start_req(1, 0, 0, 3'd5, 8'hA5, 1, 8'h00, 2'd0, 3);
    chk("wr_enable", int'(mem_enable), 1);
    chk("wr_rw",     int'(mem_rw),     1);
    chk("wr_ad_addr", int'(mem_ad),    8'h05);
    step();
    chk("wr_ad_data", int'(mem_ad),    8'hA5);
    chk("wr_data_en", int'(mem_enable), 0);
    step(); step();

    // plain read addr 3
    start_req(0, 0, 0, 3'd3, 8'hFF, 1, 8'h3C, 2'd0, 3);
    chk("rd_rw",      int'(mem_rw), 0);
    chk("rd_ad_addr", int'(mem_ad), 8'h03);
    step();
    mem_rdata = 8'h3C;
    chk("rd_ad_data", int'(mem_ad), 0);
    step();
    mem_rdata = 8'h00;
    step();

    // atomic locked write: lock + unlock
    start_req(1, 1, 1, 3'd2, 8'h5A, 1, 8'h00, 2'd0, 5);
    chk("lk_hold",   int'(mem_hold), 1);
    chk("lk_locked0", int'(locked),  0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("lk_locked1", int'(locked),   1);
    chk("lk_enable",  int'(mem_enable), 1);
    chk("lk_ad_addr", int'(mem_ad),   8'h02);
    step();
    chk("lk_ad_data", int'(mem_ad),   8'h5A);
    step();
    chk("lk_release", int'(mem_release), 1);
    chk("lk_locked_rel", int'(locked), 1);
    step();
    chk("lk_locked_end", int'(locked), 0);
    step();

    // persistent IN_USE on hold: 4 attempts, 2 idle cycles between
    mem_err = 2'd1;
    start_req(0, 1, 0, 3'd4, 8'h00, 1, 8'h00, 2'd1, 11);
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("inuse_hold_c%0d", c), int'(mem_hold), (c % 3 == 1 && c <= 10) ? 1 : 0);
      chk($sformatf("inuse_en_c%0d", c), int'(mem_enable), 0);
      if (c < 11) step();
    end
    chk("inuse_locked", int'(locked), 0);
    mem_err = 2'd0;
    step();

    // DUAL_WRITE on first ADDR, then clean retry
    start_req(1, 0, 0, 3'd6, 8'h77, 1, 8'h00, 2'd0, 6);
    chk("dw_enable1", int'(mem_enable), 1);
    mem_err = 2'd2;
    step();
    mem_err = 2'd0;
    chk("dw_bo1", int'(mem_enable), 0);
    step();
    chk("dw_bo2", int'(mem_enable), 0);
    step();
    chk("dw_enable2", int'(mem_enable), 1);
    chk("dw_ad_addr", int'(mem_ad), 8'h06);
    step();
    chk("dw_ad_data", int'(mem_ad), 8'h77);
    step(); step();

    // lock only: hold taken and kept
    start_req(0, 1, 0, 3'd0, 8'h00, 1, 8'h11, 2'd0, 4);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    mem_rdata = 8'h11;
    step();
    mem_rdata = 8'h00;
    chk("keep_locked", int'(locked), 1);
    step();

    // lock while already locked: no hold phase
    start_req(1, 1, 0, 3'd1, 8'h22, 1, 8'h00, 2'd0, 3);
    chk("relock_nohold", int'(mem_hold), 0);
    chk("relock_enable", int'(mem_enable), 1);
    step(); step(); step();

    // unlock only: release after data
    start_req(0, 0, 1, 3'd4, 8'h00, 1, 8'h99, 2'd0, 4);
    step();
    mem_rdata = 8'h99;
    step();
    mem_rdata = 8'h00;
    chk("unl_release", int'(mem_release), 1);
    step();
    chk("unl_locked", int'(locked), 0);
    step();

    // reset during DATA: dropped silently, then a normal read
    start_req(0, 0, 0, 3'd1, 8'h00, 0, 8'h00, 2'd0, 0);
    step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", int'(req_ready), 1);
    chk("mid_rst_valid", int'(rsp_valid), 0);
    chk("mid_rst_ad",    int'(mem_ad),    0);
    chk("mid_rst_ctl",   int'({mem_rw, mem_enable, mem_hold, mem_release}), 0);
    step();
    reset_n = 1'b1;
    step();
    start_req(0, 0, 0, 3'd7, 8'h00, 1, 8'h81, 2'd0, 3);
    step();
    mem_rdata = 8'h81;
    step();
    mem_rdata = 8'h00;
    step(); step();

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
